// File: rtl/nrisc_pkg.sv
// Shared widths, opcode encodings and instruction field positions for the nRisc micro-core.
package nrisc_pkg;

    localparam int DATA_W    = 8;
    localparam int NREG      = 4;
    localparam int MEM_DEPTH = 8;
    localparam int REG_AW    = 2;
    localparam int MEM_AW    = 3;
    localparam int PROD_REG  = 2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_GZ   = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_SAVE = 3'b101;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 5;
    localparam int RD_HI   = 4;
    localparam int RD_LO   = 3;
    localparam int RS_HI   = 2;
    localparam int RS_LO   = 1;
    localparam int IMM_HI  = 2;
    localparam int IMM_LO  = 0;

endpackage

// File: rtl/nrisc_regfile.sv
// 4x8 register file: two combinational read ports, one clocked write port, async clear.
module nrisc_regfile
    import nrisc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] ra_a_i,
    input  logic [REG_AW-1:0] ra_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] prod_o
);

    logic [NREG-1:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[ra_a_i];
    assign rdata_b_o = regs_q[ra_b_i];
    assign prod_o    = regs_q[PROD_REG];

endmodule

// File: rtl/nrisc_core.sv
// Single-cycle accumulator micro-core: one external instruction per rising edge, no PC.
module nrisc_core
    import nrisc_pkg::*;
(
    input  logic [7:0]        instr,
    input  logic              CLK,
    input  logic              RESET,
    output logic              zero,
    output logic [DATA_W-1:0] result
);

    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] mul_lo;
    logic [DATA_W-1:0] mem_rdata;

    logic [MEM_DEPTH-1:0][DATA_W-1:0] mem_q;
    logic              zero_q;
    logic              zero_d;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              mem_we;

    assign op      = instr[OP_HI:OP_LO];
    assign rd      = instr[RD_HI:RD_LO];
    assign rs      = instr[RS_HI:RS_LO];
    assign addr    = instr[IMM_HI:IMM_LO];
    assign imm_ext = DATA_W'(instr[IMM_HI:IMM_LO]);

    // Truncating multiply keeps the low byte; rd == rs naturally squares.
    assign mul_lo    = rd_val * rs_val;
    assign mem_rdata = mem_q[addr];

    always_comb begin
        reg_we    = 1'b0;
        reg_wdata = rd_val;
        mem_we    = 1'b0;
        zero_d    = zero_q;
        case (op)
            OP_ADD:  begin reg_we = 1'b1; reg_wdata = rd_val + imm_ext; end
            OP_SUB:  begin reg_we = 1'b1; reg_wdata = rd_val - imm_ext; end
            OP_MUL:  begin reg_we = 1'b1; reg_wdata = mul_lo;           end
            OP_GZ:   zero_d = (rd_val == '0);
            OP_LOAD: begin reg_we = 1'b1; reg_wdata = mem_rdata;        end
            OP_SAVE: mem_we = 1'b1;
            default: ;
        endcase
    end

    nrisc_regfile u_regfile (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .ra_a_i    (rd),
        .ra_b_i    (rs),
        .rdata_a_o (rd_val),
        .rdata_b_o (rs_val),
        .we_i      (reg_we),
        .wa_i      (rd),
        .wdata_i   (reg_wdata),
        .prod_o    (result)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mem_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
            if (mem_we) mem_q[addr] <= rd_val;
        end
    end

    assign zero = zero_q;

endmodule

// File: tb/tb_nrisc_core.sv
// Scoreboard bench for nrisc_core: ISA-level model predicts (zero, result) per instruction.
module tb_nrisc_core;

    logic [7:0] instr;
    logic       CLK;
    logic       RESET;
    logic       zero;
    logic [7:0] result;

    nrisc_core dut (
        .instr  (instr),
        .CLK    (CLK),
        .RESET  (RESET),
        .zero   (zero),
        .result (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [7:0] NOP = 8'hE0;

    // Architectural reference state
    int unsigned R[4];
    int unsigned M[8];
    bit          Z;

    typedef struct packed {
        logic       z;
        logic [7:0] res;
        logic [7:0] ins;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) R[i] = 0;
        for (int i = 0; i < 8; i++) M[i] = 0;
        Z = 1'b0;
    endfunction

    function automatic void model_step(input logic [7:0] ins);
        int unsigned d, s, k;
        d = ins[4:3];
        s = ins[2:1];
        k = ins[2:0];
        case (ins[7:5])
            3'd0: R[d] = (R[d] + k) % 256;
            3'd1: R[d] = (R[d] + 256 - k) % 256;
            3'd2: R[d] = (R[d] * R[s]) % 256;
            3'd3: Z = (R[d] == 0);
            3'd4: R[d] = M[k];
            3'd5: M[k] = R[d];
            default: ;
        endcase
    endfunction

    // One instruction per full cycle; NOP is parked on the bus in between.
    task automatic exec(input logic [7:0] ins);
        exp_t e;
        @(negedge CLK);
        instr = ins;
        model_step(ins);
        e.z   = Z;
        e.res = 8'(R[2]);
        e.ins = ins;
        expq.push_back(e);
        @(posedge CLK);
        #1 instr = NOP;
    endtask

    task automatic chk_out(input string name, input logic z, input logic [7:0] r);
        #2 chk(name, {7'd0, zero, result}, {7'd0, z, r});
    endtask

    // Expose hidden registers and memory through result (R2).
    task automatic probe();
        exec(8'h07 | 8'h00);
        for (int i = 0; i < 8; i++) exec(8'h90 | 8'(i));
        exec(8'hA7 | 8'h00);  exec(8'h97);
        exec(8'hA7 | 8'h08);  exec(8'h97);
        exec(8'hA7 | 8'h18);  exec(8'h97);
    endtask

    task automatic do_reset_mid();
        #2 RESET = 1'b0;
        model_reset();
        #1 chk("async_reset", {7'd0, zero, result}, 16'd0);
        instr = 8'h11;
        repeat (2) @(posedge CLK);
        #1 chk("clock_ignored_in_reset", {7'd0, zero, result}, 16'd0);
        instr = NOP;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Monitor: every executed instruction has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET && expq.size() > 0) begin
                e = expq.pop_front();
                chk($sformatf("exec_%02h", e.ins), {7'd0, zero, result}, {7'd0, e.z, e.res});
            end
        end
    end

    initial begin
        instr = NOP;
        RESET = 1'b0;
        model_reset();
        #3 chk("reset_state", {7'd0, zero, result}, 16'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Factorial 3! : preamble then three loop passes.
        // Loop reloads the product from M0 and the counter from M1 (0x99).
        exec(8'h01); exec(8'h09); exec(8'h09); exec(8'h09); exec(8'hA0); exec(8'hA9);
        exec(8'h90); exec(8'h99); exec(8'h56); exec(8'h39); exec(8'hB0); exec(8'hB9); exec(8'h7C);
        chk_out("fact_pass1", 1'b0, 8'd3);
        exec(8'h90); exec(8'h99); exec(8'h56); exec(8'h39); exec(8'hB0); exec(8'hB9); exec(8'h7C);
        chk_out("fact_pass2", 1'b0, 8'd6);
        exec(8'h90); exec(8'h99); exec(8'h56); exec(8'h39); exec(8'hB0); exec(8'hB9); exec(8'h7C);
        chk_out("fact_pass3", 1'b1, 8'd6);

        // Reset mid-run with nonzero state everywhere
        do_reset_mid();
        probe();

        // Arithmetic wrap
        exec(8'h21); exec(8'h07);
        exec(8'h17); exec(8'h17); exec(8'h12);
        chk_out("r2_is_0x10", 1'b0, 8'h10);
        exec(8'h1F); exec(8'h1F); exec(8'h1F); exec(8'h1F); exec(8'h1C);
        exec(8'h56);
        chk_out("mul_wrap", 1'b0, 8'h00);
        probe();

        // Memory forwarding: SAVE then LOAD same address next cycle
        do_reset_mid();
        exec(8'h0D); exec(8'hAF); exec(8'h97);
        chk_out("save_load_fwd", 1'b0, 8'd5);
        for (int i = 0; i < 7; i++) exec(8'h90 | 8'(i));
        chk_out("other_addr_zero", 1'b0, 8'd0);

        // Flag isolation
        do_reset_mid();
        exec(8'h7C);
        chk_out("gz_on_zero", 1'b1, 8'd0);
        exec(8'h01); exec(8'h21); exec(8'h56); exec(8'h90); exec(8'hA0);
        chk_out("zero_sticky", 1'b1, 8'd0);
        exec(8'h02); exec(8'h1A); exec(8'h5E); exec(8'h5E);
        exec(8'h58); exec(8'h58); exec(8'h58);
        exec(8'h78);
        chk_out("gz_on_0x80", 1'b0, 8'd0);
        probe();

        // NOP opcodes over nonzero state
        exec(8'h13); exec(8'hB3); exec(8'h7C);
        for (int i = 8'hC0; i <= 8'hFF; i++) exec(8'(i));
        probe();

        // Randomized run with one unannounced reset
        for (int n = 0; n < 400; n++) begin
            exec(8'($urandom_range(0, 255)));
            if (n == 200) do_reset_mid();
            if (n % 100 == 99) probe();
        end
        probe();

        for (int t = 0; t < 10 && expq.size() > 0; t++) @(posedge CLK);
        #3;
        if (expq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
